hp_bus_probe: RTL and testbench

- Wishbone-slave capture engine for the HP-35 serial word buses (carry, ia, bcd, ws, is, sync, ...).
- Replaces the hard-wired logic-analyser debug taps with a parametrised, register-mapped probe.
- Samples NCH serial channels bit-by-bit on phi2, frames each word on the sync falling edge, and buffers DEPTH complete frames for firmware readback.
- Sits in user_project_wrapper beside hp35_core on the wb_clk_i domain; its irq_o drives user_irq[1].

---
 rtl/hp_probe_pkg.sv | 24 ++
 rtl/hp_probe_fifo.sv | 62 ++++++
 rtl/hp_bus_probe.sv | 152 +++++++++++++++
 tb/tb_hp_bus_probe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hp_probe_pkg.sv
// Shared register map, bit positions and FSM encoding for the HP-35 bus probe.
package hp_probe_pkg;

  localparam logic [7:0] REG_CTRL    = 8'h00;
  localparam logic [7:0] REG_STATUS  = 8'h04;
  localparam logic [7:0] REG_POP     = 8'h08;
  localparam logic [7:0] REG_CH_BASE = 8'h40;

  localparam int unsigned CTRL_ARM    = 0;
  localparam int unsigned CTRL_CONT   = 1;
  localparam int unsigned CTRL_CLEAR  = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;

  localparam int unsigned ST_BUSY  = 4;
  localparam int unsigned ST_OVF   = 5;
  localparam int unsigned ST_SHORT = 6;

  typedef enum logic [1:0] {IDLE, WAIT, CAP} probe_state_e;

  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hp_probe_fifo.sv
// Frame FIFO for the bus probe; head frame is presented combinationally on dout.
module hp_probe_fifo
  import hp_probe_pkg::*;
#(
  parameter int unsigned FW    = 336,
  parameter int unsigned DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        clr,
  input  logic [FW-1:0]               din,
  output logic [FW-1:0]               dout,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hp_bus_probe.sv
// Wishbone-mapped capture engine framing HP-35 serial word buses on sync and phi2.
module hp_bus_probe
  import hp_probe_pkg::*;
#(
  parameter int unsigned NCH       = 6,
  parameter int unsigned WORD_BITS = 56,
  parameter int unsigned DEPTH     = 2
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_ni,
  input  logic           wbs_cyc_i,
  input  logic           wbs_stb_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [7:0]     wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  input  logic           phi2_in,
  input  logic           sync_in,
  input  logic [NCH-1:0] ch_in,
  output logic           irq_o
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned FW = NCH * WORD_BITS;
  localparam int unsigned BW = $clog2(WORD_BITS);

  probe_state_e                      state;
  logic                              phi2_q, sync_q;
  logic                              bit_stb, sync_fall;
  logic [BW-1:0]                     bit_cnt;
  logic [NCH-1:0][WORD_BITS-1:0]     shreg;
  logic [NCH-1:0][WORD_BITS-1:0]     head;
  logic                              push_pend;
  logic                              continuous, irq_en, ovf, short_err;
  logic [CW-1:0]                     count;
  logic                              full, empty;
  logic [3:0]                        cnt4;

  logic        req, wr, rd;
  logic        ctrl_wr, status_wr, pop_wr, arm, clear;
  logic [31:0] rdata;
  logic [63:0] word64;

  assign bit_stb   = phi2_in & ~phi2_q;
  assign sync_fall = sync_q & ~sync_in;

  assign req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr        = req & wbs_we_i & wbs_sel_i[0];
  assign rd        = req & ~wbs_we_i;
  assign ctrl_wr   = wr & (wbs_adr_i == REG_CTRL);
  assign status_wr = wr & (wbs_adr_i == REG_STATUS);
  assign pop_wr    = wr & (wbs_adr_i == REG_POP);
  assign arm       = ctrl_wr & wbs_dat_i[CTRL_ARM];
  assign clear     = ctrl_wr & wbs_dat_i[CTRL_CLEAR];
  assign cnt4      = 4'(count);

  hp_probe_fifo #(.FW(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .push  (push_pend),
    .pop   (pop_wr),
    .clr   (clear),
    .din   (shreg),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    rdata  = '0;
    word64 = '0;
    for (int unsigned c = 0; c < NCH; c++)
      if (32'(wbs_adr_i[5:3]) == c) word64[WORD_BITS-1:0] = head[c];
    if (wbs_adr_i == REG_CTRL)
      rdata = 32'({irq_en, 1'b0, continuous, 1'b0});
    else if (wbs_adr_i == REG_STATUS)
      rdata = 32'({short_err, ovf, (state != IDLE), cnt4});
    else if (wbs_adr_i[7:6] == REG_CH_BASE[7:6] && wbs_adr_i[1:0] == 2'b00)
      rdata = wbs_adr_i[2] ? word64[63:32] : word64[31:0];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state      <= IDLE;
      phi2_q     <= 1'b0;
      sync_q     <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      push_pend  <= 1'b0;
      continuous <= 1'b0;
      irq_en     <= 1'b0;
      ovf        <= 1'b0;
      short_err  <= 1'b0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      irq_o      <= 1'b0;
    end else begin
      phi2_q    <= phi2_in;
      sync_q    <= sync_in;
      push_pend <= 1'b0;
      wbs_ack_o <= req;
      wbs_dat_o <= rd ? rdata : '0;
      irq_o     <= irq_en & (count != '0);

      if (ctrl_wr) begin
        continuous <= wbs_dat_i[CTRL_CONT];
        irq_en     <= wbs_dat_i[CTRL_IRQ_EN];
      end
      if (status_wr) begin
        if (wbs_dat_i[ST_OVF])   ovf       <= 1'b0;
        if (wbs_dat_i[ST_SHORT]) short_err <= 1'b0;
      end
      if (push_pend && full && !pop_wr) ovf <= 1'b1;

      case (state)
        IDLE: if (arm) state <= WAIT;
        WAIT: if (sync_fall) begin
          state   <= CAP;
          bit_cnt <= '0;
        end
        CAP: begin
          // A sync fall mid-word wins over a coincident bit strobe.
          if (sync_fall) begin
            bit_cnt   <= '0;
            short_err <= 1'b1;
          end else if (bit_stb) begin
            for (int unsigned c = 0; c < NCH; c++)
              shreg[c] <= {ch_in[c], shreg[c][WORD_BITS-1:1]};
            if (bit_cnt == BW'(WORD_BITS - 1)) begin
              push_pend <= 1'b1;
              state     <= continuous ? WAIT : IDLE;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (clear) begin
        state     <= IDLE;
        ovf       <= 1'b0;
        short_err <= 1'b0;
        push_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hp_bus_probe.sv
// Directed bench for hp_bus_probe: capture, overflow, short word, push/pop overlap, reset, bus protocol.
module tb_hp_bus_probe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [7:0]  adr = 8'h00;
  logic [31:0] wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        phi2 = 1'b0, sync = 1'b0;
  logic [5:0]  ch = '0;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rv;

  localparam logic [63:0] P1 = 64'h00A55A5A5A5A5A5A;
  localparam logic [63:0] W1 = 64'h000123456789ABCD;
  localparam logic [63:0] W2 = 64'h00FEDCBA98765432;
  localparam logic [63:0] W3 = 64'h0013579BDF02468A;
  localparam logic [63:0] W4 = 64'h002468ACE13579BD;

  hp_bus_probe #(.NCH(6), .WORD_BITS(56), .DEPTH(2)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .phi2_in   (phi2),
    .sync_in   (sync),
    .ch_in     (ch),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
    tick();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    tick();
    d = rdat;
    cyc = 1'b0; stb = 1'b0;
    tick();
  endtask

  task automatic send_bit(input logic b);
    ch = {4'b0000, ~b, b};
    phi2 = 1'b1;
    tick(); tick();
    phi2 = 1'b0;
    tick(); tick();
  endtask

  task automatic sync_pulse();
    sync = 1'b1;
    tick(); tick();
    sync = 1'b0;
    tick(); tick();
  endtask

  task automatic send_word(input logic [63:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_dat", rdat, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    tick();
    wb_read(8'h04, rv); check("rst_status", rv, 32'h0000_0000);

    // Single capture, irq disabled
    wb_write(8'h00, 32'h1, 4'h1);
    wb_read(8'h04, rv); check("armed_busy", rv, 32'h0000_0010);
    sync_pulse();
    send_word(P1, 56);
    wb_read(8'h04, rv); check("cap_status", rv, 32'h0000_0001);
    check("cap_irq_off", {31'b0, irq}, 32'h0);
    wb_read(8'h40, rv); check("ch0_lo", rv, 32'h5A5A5A5A);
    wb_read(8'h44, rv); check("ch0_hi", rv, 32'h00A55A5A);
    wb_read(8'h48, rv); check("ch1_lo", rv, 32'hA5A5A5A5);
    wb_read(8'h4C, rv); check("ch1_hi", rv, 32'h005AA5A5);
    wb_read(8'h50, rv); check("ch2_lo", rv, 32'h0);
    wb_read(8'h70, rv); check("ch6_unmapped", rv, 32'h0);
    wb_write(8'h00, 32'h8, 4'h1);
    check("irq_on", {31'b0, irq}, 32'h1);
    wb_read(8'h00, rv); check("ctrl_rb", rv, 32'h0000_0008);

    // Pop to empty
    wb_write(8'h08, 32'h0, 4'h1);
    wb_read(8'h04, rv); check("pop_status", rv, 32'h0000_0000);
    check("pop_irq", {31'b0, irq}, 32'h0);
    wb_read(8'h40, rv); check("empty_read", rv, 32'h0);

    // Continuous mode with overflow
    wb_write(8'h00, 32'h3, 4'h1);
    sync_pulse(); send_word(W1, 56);
    sync_pulse(); send_word(W2, 56);
    sync_pulse(); send_word(W3, 56);
    wb_read(8'h04, rv); check("ovf_status", rv, 32'h0000_0032);
    wb_read(8'h40, rv); check("ovf_head_lo", rv, 32'h6789ABCD);
    wb_read(8'h44, rv); check("ovf_head_hi", rv, 32'h00012345);
    wb_write(8'h08, 32'h0, 4'h1);
    wb_read(8'h40, rv); check("w2_lo", rv, 32'h98765432);
    wb_read(8'h44, rv); check("w2_hi", rv, 32'h00FEDCBA);
    wb_read(8'h04, rv); check("after_pop", rv, 32'h0000_0031);
    wb_write(8'h04, 32'h20, 4'h1);
    wb_read(8'h04, rv); check("ovf_w1c", rv, 32'h0000_0011);

    // Short word then intact full word
    sync_pulse(); send_word(W1, 20);
    sync_pulse(); send_word(W3, 56);
    wb_read(8'h04, rv); check("short_status", rv, 32'h0000_0052);
    wb_write(8'h08, 32'h0, 4'h1);
    wb_read(8'h40, rv); check("w3_lo", rv, 32'hDF02468A);
    wb_read(8'h44, rv); check("w3_hi", rv, 32'h0013579B);
    wb_write(8'h04, 32'h40, 4'h1);
    wb_read(8'h04, rv); check("short_w1c", rv, 32'h0000_0011);

    // Push and pop in the same cycle
    sync_pulse();
    send_word(W4, 55);
    ch = {4'b0000, ~W4[55], W4[55]};
    phi2 = 1'b1;
    tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h08; wdat = '0; sel = 4'h1;
    tick();
    check("pp_ack", {31'b0, ack}, 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; phi2 = 1'b0;
    tick(); tick();
    wb_read(8'h04, rv); check("pp_status", rv, 32'h0000_0011);
    wb_read(8'h40, rv); check("pp_head_lo", rv, 32'hE13579BD);
    wb_read(8'h44, rv); check("pp_head_hi", rv, 32'h002468AC);

    // Clear
    wb_write(8'h00, 32'h4, 4'h1);
    wb_read(8'h04, rv); check("clear_status", rv, 32'h0000_0000);

    // Reset mid-capture
    wb_write(8'h00, 32'h9, 4'h1);
    sync_pulse();
    send_word(P1, 30);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", {31'b0, ack}, 32'h0);
    check("mid_rst_dat", rdat, 32'h0);
    check("mid_rst_irq", {31'b0, irq}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    wb_read(8'h04, rv); check("post_rst_status", rv, 32'h0000_0000);
    sync_pulse(); send_word(P1, 56);
    wb_read(8'h04, rv); check("no_frame_status", rv, 32'h0000_0000);
    wb_read(8'h40, rv); check("no_frame_data", rv, 32'h0);

    // Wishbone protocol
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h04; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("b2b_ack%0d", i), {31'b0, ack}, (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    cyc = 1'b0; stb = 1'b0;
    tick();
    wb_write(8'h00, 32'h1, 4'hE);
    wb_read(8'h04, rv); check("sel0_ignored", rv, 32'h0000_0000);
    wb_read(8'h80, rv); check("unmapped_read", rv, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
